// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: pops PS/2 set-2 bytes from the receiver FIFO, folds the
// E0/F0 prefixes into single key events, tracks Shift/Caps and presents each
// event with its ASCII translation over a valid/ready handshake.
// Optional build macro: TYPEMATIC_FILTER_EN suppresses auto-repeat presses.
`timescale 1ns/1ps

module ps2_scancode_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             kb_ready,
   input  logic [7:0]       kb_data,
   input  logic             kb_overflow,
   output logic             kb_next,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [7:0]       ev_code,
   output logic             ev_ext,
   output logic             ev_break,
   output logic [7:0]       ev_ascii,
   output logic             shift,
   output logic             caps,
   output logic [CNT_W-1:0] make_cnt,
   output logic             ovf_seen
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GOT_E0   = 2'd1,
      GOT_F0   = 2'd2,
      GOT_E0F0 = 2'd3
   } state_t;

   localparam logic [7:0] PFX_E0 = 8'hE0;
   localparam logic [7:0] PFX_F0 = 8'hF0;

   state_t state_q, state_d;
   logic   emit;        // consumed byte completes a key sequence
   logic   emit_ext;
   logic   emit_brk;
   logic   fire;        // completed sequence actually produces an event
   logic   shift_l_q;   // left Shift (12) held
   logic   shift_r_q;   // right Shift (59) held

   // Set-2 code to ASCII; letters are shifted to uppercase when upper=1.
   function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic upper);
      logic [7:0] letter;
      logic [7:0] other;
      letter = 8'h00;
      other  = 8'h00;
      case (code)
         8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
         8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
         8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
         8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
         8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
         8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
         8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
         8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
         8'h35: letter = "y";  8'h1A: letter = "z";
         8'h45: other = "0";   8'h16: other = "1";   8'h1E: other = "2";
         8'h26: other = "3";   8'h25: other = "4";   8'h2E: other = "5";
         8'h36: other = "6";   8'h3D: other = "7";   8'h3E: other = "8";
         8'h46: other = "9";
         8'h29: other = 8'h20;
         8'h5A: other = 8'h0D;
         8'h66: other = 8'h08;
         default: ;
      endcase
      if (letter != 8'h00)
         return upper ? (letter - 8'h20) : letter;
      return other;
   endfunction

   // Pop whenever a byte is waiting and no event is stalled downstream.
   assign kb_next = kb_ready & ~ev_valid & rst;
   assign shift   = shift_l_q | shift_r_q;

   // Prefix state register.
   // NOTE: synchronous reset -- rst is only looked at on the clock edge, so it belongs inside the clocked branch.
   always_ff @(posedge clk) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state and sequence-completion decode for the consumed byte.
   // NOTE: every combinational output is given a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      emit     = 1'b0;
      emit_ext = 1'b0;
      emit_brk = 1'b0;
      if (kb_next) begin
         case (state_q)
            IDLE: begin
               if (kb_data == PFX_E0)      state_d = GOT_E0;
               else if (kb_data == PFX_F0) state_d = GOT_F0;
               else begin
                  emit    = 1'b1;
                  state_d = IDLE;
               end
            end
            GOT_E0: begin
               if (kb_data == PFX_E0)      state_d = GOT_E0;
               else if (kb_data == PFX_F0) state_d = GOT_E0F0;
               else begin
                  emit     = 1'b1;
                  emit_ext = 1'b1;
                  state_d  = IDLE;
               end
            end
            GOT_F0: begin
               if (kb_data == PFX_F0)      state_d = GOT_F0;
               else if (kb_data == PFX_E0) state_d = GOT_E0;
               else begin
                  emit     = 1'b1;
                  emit_brk = 1'b1;
                  state_d  = IDLE;
               end
            end
            GOT_E0F0: begin
               if (kb_data == PFX_F0)      state_d = GOT_E0F0;
               else if (kb_data == PFX_E0) state_d = GOT_E0;
               else begin
                  emit     = 1'b1;
                  emit_ext = 1'b1;
                  emit_brk = 1'b1;
                  state_d  = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef TYPEMATIC_FILTER_EN
   logic       last_vld_q;
   logic [8:0] last_key_q;   // {ext, code} of the most recent accepted press
   logic       key_match;

   assign key_match = last_vld_q & (last_key_q == {emit_ext, kb_data});
   assign fire      = emit & ~(~emit_brk & key_match);

   // Remember the held key so its auto-repeat presses can be swallowed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_vld_q <= 1'b0;
         last_key_q <= 9'h000;
      end else if (emit) begin
         if (emit_brk) begin
            if (key_match)
               last_vld_q <= 1'b0;
         end else begin
            last_vld_q <= 1'b1;
            last_key_q <= {emit_ext, kb_data};
         end
      end
   end
`else
   assign fire = emit;
`endif

   // Event register, modifier tracking, press counter and sticky overflow flag.
   // NOTE: state is updated with non-blocking assignments so every read in this block sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ev_valid  <= 1'b0;
         ev_code   <= 8'h00;
         ev_ext    <= 1'b0;
         ev_break  <= 1'b0;
         ev_ascii  <= 8'h00;
         shift_l_q <= 1'b0;
         shift_r_q <= 1'b0;
         caps      <= 1'b0;
         make_cnt  <= '0;
         ovf_seen  <= 1'b0;
      end else begin
         if (kb_overflow)
            ovf_seen <= 1'b1;
         if (ev_valid && ev_ready)
            ev_valid <= 1'b0;
         // fire implies kb_next, which implies no event is pending
         if (fire) begin
            ev_valid <= 1'b1;
            ev_code  <= kb_data;
            ev_ext   <= emit_ext;
            ev_break <= emit_brk;
            ev_ascii <= (emit_ext || emit_brk) ? 8'h00 : ascii_of(kb_data, shift ^ caps);
            if (!emit_ext) begin
               if (kb_data == 8'h12)
                  shift_l_q <= ~emit_brk;
               if (kb_data == 8'h59)
                  shift_r_q <= ~emit_brk;
               if (kb_data == 8'h58 && !emit_brk)
                  caps <= ~caps;
            end
            if (!emit_brk)
               make_cnt <= make_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed and randomized byte streams fed through a
// FIFO model; a reference model computes expected events into a scoreboard
// queue and a monitor compares every event the decoder hands downstream.
`timescale 1ns/1ps

module tb_ps2_scancode_decoder;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             kb_ready;
   logic [7:0]       kb_data;
   logic             kb_overflow;
   logic             kb_next;
   logic             ev_valid;
   logic             ev_ready;
   logic [7:0]       ev_code;
   logic             ev_ext;
   logic             ev_break;
   logic [7:0]       ev_ascii;
   logic             shift;
   logic             caps;
   logic [CNT_W-1:0] make_cnt;
   logic             ovf_seen;

   ps2_scancode_decoder #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .kb_ready   (kb_ready),
      .kb_data    (kb_data),
      .kb_overflow(kb_overflow),
      .kb_next    (kb_next),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_code    (ev_code),
      .ev_ext     (ev_ext),
      .ev_break   (ev_break),
      .ev_ascii   (ev_ascii),
      .shift      (shift),
      .caps       (caps),
      .make_cnt   (make_cnt),
      .ovf_seen   (ovf_seen)
   );

   always #5 clk = ~clk;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic [7:0] ascii;
      logic       shift;
      logic       caps;
      logic [7:0] cnt;
   } ev_t;

   int   checks = 0;
   int   errors = 0;
   int   n_events = 0;
   ev_t  exp_q[$];
   bq_t  fifo;
   logic rand_ready;

   // Reference model state: pending prefixes, held modifiers, press count.
   logic       m_ext, m_brk, m_shl, m_shr, m_caps;
   int         m_cnt;
   logic       m_last_vld;
   logic [8:0] m_last;

   logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
      8'h36, 8'h3D, 8'h3E, 8'h46};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_ascii(input logic [7:0] code, input logic upper);
      for (int i = 0; i < 26; i++)
         if (letter_codes[i] == code) return 8'((upper ? 65 : 97) + i);
      for (int i = 0; i < 10; i++)
         if (digit_codes[i] == code) return 8'(48 + i);
      if (code == 8'h29) return 8'h20;
      if (code == 8'h5A) return 8'h0D;
      if (code == 8'h66) return 8'h08;
      return 8'h00;
   endfunction

   task automatic model_reset();
      m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_caps = 0;
      m_cnt = 0; m_last_vld = 0; m_last = '0;
      exp_q.delete();
   endtask

   // E0 marks the key as extended and cancels any earlier F0; F0 marks a release;
   // any other byte completes the key with the accumulated flags.
   task automatic model_byte(input logic [7:0] b);
      ev_t  e;
      logic suppress;
      logic [8:0] key;
      if (b == 8'hE0) begin
         m_ext = 1; m_brk = 0;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         key = {m_ext, b};
         suppress = 0;
`ifdef TYPEMATIC_FILTER_EN
         if (!m_brk) begin
            if (m_last_vld && m_last == key) suppress = 1;
            else begin m_last = key; m_last_vld = 1; end
         end else if (m_last_vld && m_last == key) begin
            m_last_vld = 0;
         end
`endif
         if (!suppress) begin
            e.code  = b;
            e.ext   = m_ext;
            e.brk   = m_brk;
            e.ascii = (m_ext || m_brk) ? 8'h00 : ref_ascii(b, (m_shl | m_shr) ^ m_caps);
            if (!m_ext) begin
               if (b == 8'h12) m_shl = !m_brk;
               if (b == 8'h59) m_shr = !m_brk;
               if (b == 8'h58 && !m_brk) m_caps = !m_caps;
            end
            if (!m_brk) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            e.shift = m_shl | m_shr;
            e.caps  = m_caps;
            e.cnt   = 8'(m_cnt);
            exp_q.push_back(e);
         end
         m_ext = 0; m_brk = 0;
      end
   endtask

   // Receiver FIFO model: a byte is consumed on the edge where kb_next was high.
   initial begin
      logic pop_now;
      kb_ready = 1'b0;
      kb_data  = 8'h00;
      forever begin
         @(negedge clk);
         pop_now = kb_next;
         @(posedge clk);
         #1;
         if (pop_now) begin
            model_byte(fifo[0]);
            void'(fifo.pop_front());
         end
         kb_ready = (fifo.size() > 0);
         kb_data  = kb_ready ? fifo[0] : 8'h00;
      end
   end

   // Downstream consumer with random backpressure.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) ev_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pop-rule check every cycle, scoreboard compare on each accepted event.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            check("pop_rule", kb_next, kb_ready & ~ev_valid);
            if (ev_valid && ev_ready) begin
               n_events++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_event: got code 0x%0h with nothing expected", ev_code);
               end else begin
                  e = exp_q.pop_front();
                  check("ev_code",  ev_code,  e.code);
                  check("ev_ext",   ev_ext,   e.ext);
                  check("ev_break", ev_break, e.brk);
                  check("ev_ascii", ev_ascii, e.ascii);
                  check("shift",    shift,    e.shift);
                  check("caps",     caps,     e.caps);
                  check("make_cnt", make_cnt, e.cnt);
               end
            end
         end
      end
   end

   task automatic send(input bq_t b);
      foreach (b[i]) fifo.push_back(b[i]);
   endtask

   task automatic wait_idle(input string name);
      logic idle;
      idle = 0;
      for (int i = 0; i < 6000 && !idle; i++) begin
         @(negedge clk);
         idle = (fifo.size() == 0) && (exp_q.size() == 0) && !ev_valid && !kb_ready;
      end
      check(name, idle, 1'b1);
   endtask

   // Reset for a few cycles; optional byte is queued while reset is held.
   task automatic do_reset(input logic push_1c);
      @(posedge clk);
      #2;
      rst = 1'b0;
      model_reset();
      if (push_1c) fifo.push_back(8'h1C);
      repeat (3) @(posedge clk);
      @(negedge clk);
      if (push_1c) check("rst_kb_next", kb_next, 1'b0);
      check("rst_ev_valid", ev_valid, 1'b0);
      check("rst_ev_fields", {ev_code, ev_ext, ev_break, ev_ascii}, 18'h0);
      check("rst_mods", {shift, caps}, 2'b00);
      check("rst_make_cnt", make_cnt, 8'h00);
      check("rst_ovf_seen", ovf_seen, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
   endtask

   function automatic logic [7:0] rand_byte();
      int p;
      p = $urandom_range(0, 15);
      case (p)
         0, 1:  return 8'hE0;
         2, 3:  return 8'hF0;
         4:     return 8'h12;
         5:     return 8'h59;
         6:     return 8'h58;
         7, 8, 9, 10: return letter_codes[$urandom_range(0, 25)];
         11, 12: return digit_codes[$urandom_range(0, 9)];
         13: begin
            case ($urandom_range(0, 2))
               0: return 8'h29;
               1: return 8'h5A;
               default: return 8'h66;
            endcase
         end
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      int   base;
      int   bad;
      logic [7:0] cap_ascii, cap_code;
      logic got;
      bq_t  rb;

      rst = 1'b0;
      ev_ready = 1'b0;
      kb_overflow = 1'b0;
      rand_ready = 1'b1;
      model_reset();
      do_reset(1'b0);

      // press and release of 'a'
      send('{8'h1C, 8'hF0, 8'h1C});
      wait_idle("t1_drain");
      check("t1_make_cnt", make_cnt, 8'd1);

      // Shift and Caps interplay
      do_reset(1'b0);
      send('{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h58, 8'hF0, 8'h58, 8'h1C});
      wait_idle("t2_drain");
      check("t2_shift", shift, 1'b0);
      check("t2_caps", caps, 1'b1);

      // extended key leaves modifiers alone
      send('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
      wait_idle("t3_drain");
      check("t3_caps", caps, 1'b1);

      // downstream stall: one event held, nothing popped
      do_reset(1'b0);
      rand_ready = 1'b0;
      ev_ready = 1'b0;
      send('{8'h16, 8'h1E});
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = ev_valid;
      end
      check("stall_valid", got, 1'b1);
      cap_ascii = ev_ascii;
      cap_code  = ev_code;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (kb_next !== 1'b0 || ev_valid !== 1'b1 || ev_ascii !== cap_ascii || ev_code !== cap_code)
            bad++;
      end
      check("stall_hold", bad, 0);
      check("stall_ascii", ev_ascii, 8'h31);
      check("stall_fifo_left", fifo.size(), 1);
      @(posedge clk);
      #2;
      rand_ready = 1'b1;
      wait_idle("stall_drain");

      // malformed F0 E0 F0 sequence, then reset after a lone E0
      do_reset(1'b0);
      send('{8'hF0, 8'hE0, 8'hF0, 8'h6B});
      wait_idle("t5_drain");
      send('{8'hE0});
      wait_idle("t5_e0_consumed");
      base = n_events;
      do_reset(1'b1);
      wait_idle("t5_post_reset");
      check("t5_post_reset_events", n_events - base, 1);

      // pending event dropped by reset
      rand_ready = 1'b0;
      ev_ready = 1'b0;
      send('{8'h32});
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = ev_valid;
      end
      check("drop_valid", got, 1'b1);
      do_reset(1'b0);
      rand_ready = 1'b1;

      // auto-repeat stream
      base = n_events;
      send('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C});
      wait_idle("tm_drain");
`ifdef TYPEMATIC_FILTER_EN
      check("tm_events", n_events - base, 3);
      check("tm_make_cnt", make_cnt, 8'd2);
`else
      check("tm_events", n_events - base, 5);
      check("tm_make_cnt", make_cnt, 8'd4);
`endif

      // counter wrap with alternating keys
      for (int i = 0; i < 260; i++) send('{(i % 2 == 0) ? 8'h1C : 8'h32});
      wait_idle("wrap_drain");
      check("wrap_make_cnt", make_cnt, 8'(m_cnt));

      // overflow flag is sticky
      @(posedge clk);
      #2;
      kb_overflow = 1'b1;
      @(posedge clk);
      #2;
      kb_overflow = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("ovf_seen", ovf_seen, 1'b1);

      // randomized byte stream
      for (int i = 0; i < 600; i++) rb.push_back(rand_byte());
      send(rb);
      wait_idle("rand_drain");
      check("rand_ovf_sticky", ovf_seen, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
